// File: rtl/collision_pkg.sv
// collision_pkg: FSM state encoding and parameter defaults shared by the collision engine.
package collision_pkg;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_SCAN = 2'd1;
  localparam state_t S_REPORT = 2'd2;
  localparam int COORD_W_D = 10;
  localparam int N_BULLETS_D = 4;
  localparam int TARGET_W_D = 30;
  localparam int TARGET_Y_D = 60;
  localparam int HALF_H_D = 10;
  localparam int LOCKOUT_D = 8;
endpackage

// File: rtl/hitbox_cmp.sv
// hitbox_cmp: inclusive single-bullet hitbox test, widened two bits so edges never wrap.
module hitbox_cmp
  import collision_pkg::*;
#(
  parameter int COORD_W = COORD_W_D,
  parameter int TARGET_W = TARGET_W_D,
  parameter int TARGET_Y = TARGET_Y_D,
  parameter int HALF_H = HALF_H_D
) (
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] tx,
  input  logic               valid,
  output logic               hit
);
  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] Y_LO = SW'(TARGET_Y - HALF_H);
  localparam logic signed [SW-1:0] Y_HI = SW'(TARGET_Y + HALF_H);
  logic signed [SW-1:0] sx, sy, x_lo, x_hi;
  always_comb begin
    sx = $signed({2'b00, bx});
    sy = $signed({2'b00, by});
    x_lo = $signed({2'b00, tx});
    x_hi = x_lo + $signed(SW'(TARGET_W));
    hit = valid && sx >= x_lo && sx <= x_hi && sy >= Y_LO && sy <= Y_HI;
  end
endmodule

// File: rtl/collision_engine.sv
// collision_engine: per-frame sequential bullet/target hit scan with lockout, counter and overrun flag.
module collision_engine
  import collision_pkg::*;
#(
  parameter int COORD_W = COORD_W_D,
  parameter int N_BULLETS = N_BULLETS_D,
  parameter int TARGET_W = TARGET_W_D,
  parameter int TARGET_Y = TARGET_Y_D,
  parameter int HALF_H = HALF_H_D,
  parameter int LOCKOUT = LOCKOUT_D
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_tick,
  input  logic [N_BULLETS*COORD_W-1:0]   bullet_x,
  input  logic [N_BULLETS*COORD_W-1:0]   bullet_y,
  input  logic [N_BULLETS-1:0]           bullet_valid,
  input  logic [COORD_W-1:0]             target_x,
  input  logic                           count_clr,
  output logic                           hit,
  output logic [N_BULLETS-1:0]           hit_mask,
  output logic [7:0]                     hit_count,
  output logic                           busy,
  output logic                           locked,
  output logic                           overrun
);
  localparam int IW = N_BULLETS > 1 ? $clog2(N_BULLETS) : 1;
  localparam int LW = LOCKOUT > 0 ? $clog2(LOCKOUT + 1) : 1;
  state_t state;
  logic [N_BULLETS*COORD_W-1:0] bx_q, by_q;
  logic [N_BULLETS-1:0] bv_q, acc, final_mask;
  logic [COORD_W-1:0] tx_q;
  logic [IW-1:0] idx;
  logic [LW-1:0] lock_cnt;
  logic ch_hit, last, done_hit;
  hitbox_cmp #(
    .COORD_W(COORD_W),
    .TARGET_W(TARGET_W),
    .TARGET_Y(TARGET_Y),
    .HALF_H(HALF_H)
  ) u_cmp (
    .bx(bx_q[idx*COORD_W +: COORD_W]),
    .by(by_q[idx*COORD_W +: COORD_W]),
    .tx(tx_q),
    .valid(bv_q[idx]),
    .hit(ch_hit)
  );
  always_comb begin
    last = idx == IW'(N_BULLETS - 1);
    final_mask = acc | (N_BULLETS'(ch_hit) << idx);
    done_hit = state == S_SCAN && last && |final_mask;
    busy = state != S_IDLE;
    locked = lock_cnt != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      hit <= 1'b0;
      hit_mask <= '0;
      hit_count <= 8'd0;
      overrun <= 1'b0;
      lock_cnt <= '0;
      idx <= '0;
      acc <= '0;
    end else begin
      hit <= 1'b0;
      overrun <= frame_tick && busy;
      hit_count <= count_clr ? 8'd0 : (done_hit && hit_count != 8'hff) ? hit_count + 8'd1 : hit_count;
      if (state == S_IDLE && frame_tick) begin
        if (locked) begin
          lock_cnt <= lock_cnt - 1'b1;
          hit_mask <= '0;
        end else begin
          bx_q <= bullet_x;
          by_q <= bullet_y;
          bv_q <= bullet_valid;
          tx_q <= target_x;
          idx <= '0;
          acc <= '0;
          state <= S_SCAN;
        end
      end else if (state == S_SCAN) begin
        acc <= final_mask;
        idx <= idx + 1'b1;
        if (last) begin
          state <= S_REPORT;
          hit_mask <= final_mask;
          hit <= |final_mask;
          if (|final_mask) lock_cnt <= LW'(LOCKOUT);
        end
      end else if (state == S_REPORT) begin
        state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_collision_engine.sv
// tb_collision_engine: directed checks of timing, hitbox edges, lockout, overrun, reset and saturation.
module tb_collision_engine;
  logic clk = 1'b0;
  logic rst, frame_tick, count_clr;
  logic [39:0] bullet_x, bullet_y;
  logic [3:0] bullet_valid, hit_mask;
  logic [9:0] target_x;
  logic hit, busy, locked, overrun;
  logic [7:0] hit_count;
  int tests = 0;
  int fails = 0;
  int bn;
  logic he;
  always #5 clk = ~clk;
  collision_engine dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .bullet_valid(bullet_valid), .target_x(target_x), .count_clr(count_clr), .hit(hit),
    .hit_mask(hit_mask), .hit_count(hit_count), .busy(busy), .locked(locked), .overrun(overrun)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic setb(input int ch, input int x, input int y, input bit v);
    bullet_x[ch*10 +: 10] = 10'(x);
    bullet_y[ch*10 +: 10] = 10'(y);
    bullet_valid[ch] = v;
  endtask
  task automatic rst_dut();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic all_hit();
    target_x = 10'd100;
    for (int c = 0; c < 4; c++) setb(c, 115, 60, 1'b1);
  endtask
  // Returns in the REPORT cycle; he is hit one cycle earlier, bc counts busy samples.
  task automatic frame(input bit clr, input bit scr, output int bc, output logic early);
    bc = 0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    if (scr) begin
      bullet_valid = 4'h0;
      target_x = 10'd500;
    end
    bc += int'(busy);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bc += int'(busy);
    end
    early = hit;
    count_clr = clr;
    @(negedge clk);
    count_clr = 1'b0;
    bc += int'(busy);
  endtask
  task automatic ltick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    frame_tick = 1'b0;
    count_clr = 1'b0;
    bullet_x = '0;
    bullet_y = '0;
    bullet_valid = '0;
    target_x = '0;
    repeat (2) @(negedge clk);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_mask", 32'(hit_mask), 0);
    chk("rst_count", 32'(hit_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    target_x = 10'd100;
    setb(0, 115, 65, 1'b1);
    frame(1'b0, 1'b1, bn, he);
    chk("basic_early", 32'(he), 0);
    chk("basic_hit", 32'(hit), 1);
    chk("basic_mask", 32'(hit_mask), 32'h1);
    chk("basic_count", 32'(hit_count), 1);
    chk("basic_busy_cycles", 32'(bn), 5);
    chk("basic_locked", 32'(locked), 1);
    @(negedge clk);
    chk("basic_hit_pulse", 32'(hit), 0);
    chk("basic_busy_end", 32'(busy), 0);
    chk("basic_mask_held", 32'(hit_mask), 32'h1);
    rst_dut();
    target_x = 10'd100;
    setb(0, 100, 50, 1'b1);
    setb(1, 130, 70, 1'b1);
    setb(2, 99, 60, 1'b1);
    setb(3, 131, 60, 1'b1);
    frame(1'b0, 1'b0, bn, he);
    chk("edge_x_mask", 32'(hit_mask), 32'h3);
    rst_dut();
    setb(0, 115, 49, 1'b1);
    setb(1, 115, 71, 1'b1);
    setb(2, 115, 0, 1'b1);
    setb(3, 0, 60, 1'b1);
    frame(1'b0, 1'b0, bn, he);
    chk("edge_miss_hit", 32'(hit), 0);
    chk("edge_miss_mask", 32'(hit_mask), 0);
    chk("edge_miss_locked", 32'(locked), 0);
    rst_dut();
    setb(0, 100, 70, 1'b1);
    setb(1, 130, 50, 1'b1);
    setb(2, 115, 60, 1'b0);
    setb(3, 115, 60, 1'b1);
    frame(1'b0, 1'b0, bn, he);
    chk("edge_corner_mask", 32'(hit_mask), 32'hb);
    rst_dut();
    target_x = 10'd1000;
    setb(0, 1023, 60, 1'b1);
    setb(1, 5, 60, 1'b1);
    setb(2, 1000, 60, 1'b1);
    setb(3, 1010, 60, 1'b0);
    frame(1'b0, 1'b0, bn, he);
    chk("wide_mask", 32'(hit_mask), 32'h5);
    rst_dut();
    all_hit();
    frame(1'b0, 1'b0, bn, he);
    chk("lock_first_mask", 32'(hit_mask), 32'hf);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      ltick();
      chk("lock_busy", 32'(busy), 0);
      chk("lock_locked", 32'(locked), k < 7 ? 1 : 0);
      if (k == 0) chk("lock_mask_clr", 32'(hit_mask), 0);
    end
    frame(1'b0, 1'b0, bn, he);
    chk("lock_ninth_hit", 32'(hit), 1);
    chk("lock_ninth_count", 32'(hit_count), 2);
    rst_dut();
    all_hit();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("ovr_pulse", 32'(overrun), 1);
    @(negedge clk);
    chk("ovr_pulse_end", 32'(overrun), 0);
    chk("ovr_no_early_hit", 32'(hit), 0);
    @(negedge clk);
    chk("ovr_hit", 32'(hit), 1);
    chk("ovr_count", 32'(hit_count), 1);
    repeat (6) @(negedge clk);
    chk("ovr_single_busy", 32'(busy), 0);
    chk("ovr_single_count", 32'(hit_count), 1);
    rst_dut();
    all_hit();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_hit", 32'(hit), 0);
    chk("abort_count", 32'(hit_count), 0);
    repeat (5) @(negedge clk);
    chk("abort_no_report_hit", 32'(hit), 0);
    chk("abort_no_report_mask", 32'(hit_mask), 0);
    chk("abort_no_report_locked", 32'(locked), 0);
    rst_dut();
    all_hit();
    for (int i = 0; i < 255; i++) begin
      frame(1'b0, 1'b0, bn, he);
      @(negedge clk);
      repeat (8) ltick();
    end
    chk("sat_255", 32'(hit_count), 255);
    frame(1'b0, 1'b0, bn, he);
    chk("sat_extra_hit", 32'(hit), 1);
    chk("sat_extra_count", 32'(hit_count), 255);
    @(negedge clk);
    repeat (8) ltick();
    frame(1'b1, 1'b0, bn, he);
    chk("clr_vs_inc_hit", 32'(hit), 1);
    chk("clr_vs_inc_count", 32'(hit_count), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
